// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order scoreboard for snooped data-memory writes against a loadable table.
// Optional idle watchdog is built only when CHK_TIMEOUT_EN is defined.
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_exp,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic              extra_wr,
    output logic              timeout
);

    // state   | meaning
    // S_IDLE  | table loadable, waiting for start
    // S_CHECK | comparing each snooped write against table[ptr]
    // S_DONE  | run finished, results held until start or reset
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
    logic [DATA_W-1:0] tbl_data_q [DEPTH];
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
    logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
    logic [DATA_W-1:0] fe_data_q, fe_data_d;
    logic              extra_q, extra_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  n_start;
    logic              hit;
    logic              last_wr;
    logic              start_ok;
    logic              wr_ok;
    logic              tmo_fire;

    assign start_ok = start && (state_q != S_CHECK);
    assign wr_ok    = memwrite && (state_q == S_CHECK);
    assign n_start  = (int'(num_exp) > DEPTH) ? CNT_W'(DEPTH) : num_exp;
    assign hit      = (dataadr == tbl_addr_q[ptr_q]) && (writedata == tbl_data_q[ptr_q]);
    assign last_wr  = (CNT_W'(ptr_q) + CNT_W'(1)) == n_q;

    // Table is deliberately not reset so a program image survives a reset.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == S_IDLE) && (int'(load_idx) < DEPTH)) begin
            tbl_addr_q[load_idx] <= load_addr;
            tbl_data_q[load_idx] <= load_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        n_d       = n_q;
        match_d   = match_q;
        err_d     = err_q;
        fe_idx_d  = fe_idx_q;
        fe_addr_d = fe_addr_q;
        fe_data_d = fe_data_q;
        extra_d   = extra_q;
        pass_d    = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d       = n_start;
                    ptr_d     = '0;
                    match_d   = '0;
                    err_d     = '0;
                    fe_idx_d  = '0;
                    fe_addr_d = '0;
                    fe_data_d = '0;
                    extra_d   = 1'b0;
                    if (n_start == '0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                        pass_d  = 1'b0;
                    end
                end else if ((state_q == S_DONE) && memwrite) begin
                    extra_d = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (memwrite) begin
                    ptr_d = ptr_q + IDX_W'(1);
                    if (hit) begin
                        match_d = match_q + CNT_W'(1);
                    end else begin
                        err_d = err_q + CNT_W'(1);
                        if (err_q == '0) begin
                            fe_idx_d  = ptr_q;
                            fe_addr_d = dataadr;
                            fe_data_d = writedata;
                        end
                    end
                    if (last_wr) begin
                        state_d = S_DONE;
                        pass_d  = hit && (err_q == '0);
                    end
                end else if (tmo_fire) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            n_q       <= '0;
            match_q   <= '0;
            err_q     <= '0;
            fe_idx_q  <= '0;
            fe_addr_q <= '0;
            fe_data_q <= '0;
            extra_q   <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            n_q       <= n_d;
            match_q   <= match_d;
            err_q     <= err_d;
            fe_idx_q  <= fe_idx_d;
            fe_addr_q <= fe_addr_d;
            fe_data_q <= fe_data_d;
            extra_q   <= extra_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef CHK_TIMEOUT_EN
    // Down-counter reloaded with TIMEOUT-1; expiry is an idle CHECK cycle at zero.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
        tmo_fire  = 1'b0;
        if (start_ok) begin
            tmr_d     = TMR_W'(TIMEOUT - 1);
            timeout_d = 1'b0;
        end else if (wr_ok) begin
            tmr_d = TMR_W'(TIMEOUT - 1);
        end else if (state_q == S_CHECK) begin
            if (tmr_q == '0) begin
                tmo_fire  = 1'b1;
                timeout_d = 1'b1;
            end else begin
                tmr_d = tmr_q - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // TIMEOUT only sizes the watchdog, which is absent in this build.
    logic unused_timeout_cfg;
    logic unused_ctl;

    assign unused_timeout_cfg = (TIMEOUT != 0);
    assign unused_ctl         = start_ok ^ wr_ok;
    assign tmo_fire           = 1'b0;
    assign timeout            = 1'b0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign match_count    = match_q;
    assign err_count      = err_q;
    assign first_err_idx  = fe_idx_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_data = fe_data_q;
    assign extra_wr       = extra_q;

endmodule
